// File: rtl/red_mul_pipe.sv
// red_mul_pipe: pipelined modular multiplier, result = (a*b) mod Q by Barrett
// reduction with K = 2W and MU = floor(2^K / Q).
// Four stages with per-stage valid and elastic stalls:
//   S1 multiply, S2 quotient estimate, S3 remainder, S4 final correction.
// Optional build macro RED_MUL_RANGE_CHECK_EN adds err_o. The flag marks
// operands >= Q and forces that operation's result to zero.
module red_mul_pipe #(
  parameter int unsigned Q     = 8380417,
  parameter int unsigned W     = 23,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     result_o,
  output logic [TAG_W-1:0] tag_o
`ifdef RED_MUL_RANGE_CHECK_EN
  ,
  output logic             err_o
`endif
);

  localparam int unsigned K   = 2 * W;
  localparam int unsigned KW  = K + 1;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned RW  = W + 2;
  localparam int unsigned MPW = PW + KW;

  localparam logic [KW-1:0] MU  = KW'((64'd1 << K) / 64'(Q));
  localparam logic [RW-1:0] Q_R = RW'(Q);
`ifdef RED_MUL_RANGE_CHECK_EN
  localparam logic [W-1:0]  Q_W = W'(Q);
`endif

  // Stage registers
  logic             s1_v_q, s1_v_d;
  logic [PW-1:0]    s1_p_q, s1_p_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_v_q, s2_v_d;
  logic [RW-1:0]    s2_p_q, s2_p_d;
  logic [RW-1:0]    s2_t_q, s2_t_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s3_v_q, s3_v_d;
  logic [RW-1:0]    s3_r_q, s3_r_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
  logic             s4_v_q, s4_v_d;
  logic [W-1:0]     s4_r_q, s4_r_d;
  logic [TAG_W-1:0] s4_tag_q, s4_tag_d;
`ifdef RED_MUL_RANGE_CHECK_EN
  logic             s1_err_q, s1_err_d;
  logic             s2_err_q, s2_err_d;
  logic             s3_err_q, s3_err_d;
  logic             s4_err_q, s4_err_d;
`endif

  // Per-stage ready: a stage may load when empty or when it drains this cycle
  logic          s1_rdy, s2_rdy, s3_rdy, s4_rdy;
  logic [RW-1:0] red1, red2;

  // Ready chain and next-state for every stage
  always_comb begin
    s4_rdy   = !s4_v_q || out_ready_i;
    s3_rdy   = !s3_v_q || s4_rdy;
    s2_rdy   = !s2_v_q || s3_rdy;
    s1_rdy   = !s1_v_q || s2_rdy;

    s1_v_d   = s1_v_q;
    s1_p_d   = s1_p_q;
    s1_tag_d = s1_tag_q;
    s2_v_d   = s2_v_q;
    s2_p_d   = s2_p_q;
    s2_t_d   = s2_t_q;
    s2_tag_d = s2_tag_q;
    s3_v_d   = s3_v_q;
    s3_r_d   = s3_r_q;
    s3_tag_d = s3_tag_q;
    s4_v_d   = s4_v_q;
    s4_r_d   = s4_r_q;
    s4_tag_d = s4_tag_q;
`ifdef RED_MUL_RANGE_CHECK_EN
    s1_err_d = s1_err_q;
    s2_err_d = s2_err_q;
    s3_err_d = s3_err_q;
    s4_err_d = s4_err_q;
`endif

    // r < 3Q, so two conditional subtracts land in [0, Q-1]
    red1 = (s3_r_q >= Q_R) ? (s3_r_q - Q_R) : s3_r_q;
    red2 = (red1 >= Q_R) ? (red1 - Q_R) : red1;

    // S1: full product
    if (s1_rdy) begin
      s1_v_d = in_valid_i;
      if (in_valid_i) begin
        s1_p_d   = PW'(a_i) * PW'(b_i);
        s1_tag_d = tag_i;
`ifdef RED_MUL_RANGE_CHECK_EN
        s1_err_d = (a_i >= Q_W) || (b_i >= Q_W);
`endif
      end
    end

    // S2: quotient estimate; only the low RW bits of p are needed afterwards
    if (s2_rdy) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_t_d   = RW'((MPW'(s1_p_q) * MPW'(MU)) >> K);
        s2_p_d   = RW'(s1_p_q);
        s2_tag_d = s1_tag_q;
`ifdef RED_MUL_RANGE_CHECK_EN
        s2_err_d = s1_err_q;
`endif
      end
    end

    // S3: remainder, exact modulo 2^RW since the true value is below 3Q
    if (s3_rdy) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_r_d   = s2_p_q - (s2_t_q * Q_R);
        s3_tag_d = s2_tag_q;
`ifdef RED_MUL_RANGE_CHECK_EN
        s3_err_d = s2_err_q;
`endif
      end
    end

    // S4: final correction, held while downstream stalls
    if (s4_rdy) begin
      s4_v_d = s3_v_q;
      if (s3_v_q) begin
`ifdef RED_MUL_RANGE_CHECK_EN
        s4_r_d   = s3_err_q ? '0 : W'(red2);
        s4_err_d = s3_err_q;
`else
        s4_r_d   = W'(red2);
`endif
        s4_tag_d = s3_tag_q;
      end
    end
  end

  // Pipeline registers, cleared on reset so outputs and in-flight work drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q   <= 1'b0;
      s1_p_q   <= '0;
      s1_tag_q <= '0;
      s2_v_q   <= 1'b0;
      s2_p_q   <= '0;
      s2_t_q   <= '0;
      s2_tag_q <= '0;
      s3_v_q   <= 1'b0;
      s3_r_q   <= '0;
      s3_tag_q <= '0;
      s4_v_q   <= 1'b0;
      s4_r_q   <= '0;
      s4_tag_q <= '0;
`ifdef RED_MUL_RANGE_CHECK_EN
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
      s3_err_q <= 1'b0;
      s4_err_q <= 1'b0;
`endif
    end else begin
      s1_v_q   <= s1_v_d;
      s1_p_q   <= s1_p_d;
      s1_tag_q <= s1_tag_d;
      s2_v_q   <= s2_v_d;
      s2_p_q   <= s2_p_d;
      s2_t_q   <= s2_t_d;
      s2_tag_q <= s2_tag_d;
      s3_v_q   <= s3_v_d;
      s3_r_q   <= s3_r_d;
      s3_tag_q <= s3_tag_d;
      s4_v_q   <= s4_v_d;
      s4_r_q   <= s4_r_d;
      s4_tag_q <= s4_tag_d;
`ifdef RED_MUL_RANGE_CHECK_EN
      s1_err_q <= s1_err_d;
      s2_err_q <= s2_err_d;
      s3_err_q <= s3_err_d;
      s4_err_q <= s4_err_d;
`endif
    end
  end

  assign in_ready_o  = s1_rdy;
  assign out_valid_o = s4_v_q;
  assign result_o    = s4_r_q;
  assign tag_o       = s4_tag_q;
`ifdef RED_MUL_RANGE_CHECK_EN
  assign err_o       = s4_err_q;
`endif

endmodule

// File: tb/tb_red_mul_pipe.sv
// Bench for red_mul_pipe: a Dilithium-sized instance and a Kyber-sized
// instance, each with a scoreboard queue. Set RED_MUL_RANGE_CHECK_EN to
// also exercise err_o.
module tb_red_mul_pipe;

  localparam int unsigned QA = 8380417;
  localparam int unsigned WA = 23;
  localparam int unsigned QK = 3329;
  localparam int unsigned WK = 12;
  localparam int unsigned TW = 8;

  logic clk;
  logic rst_n;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [WA-1:0] a_a, a_b, a_res;
  logic [TW-1:0] a_tag, a_tag_o;
  logic          k_in_valid, k_in_ready, k_out_valid, k_out_ready;
  logic [WK-1:0] k_a, k_b, k_res;
  logic [TW-1:0] k_tag, k_tag_o;
`ifdef RED_MUL_RANGE_CHECK_EN
  logic          a_err, k_err;
`endif

  red_mul_pipe #(.Q(QA), .W(WA), .TAG_W(TW)) u_dil (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .a_i(a_a), .b_i(a_b), .tag_i(a_tag),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .result_o(a_res), .tag_o(a_tag_o)
`ifdef RED_MUL_RANGE_CHECK_EN
    , .err_o(a_err)
`endif
  );

  red_mul_pipe #(.Q(QK), .W(WK), .TAG_W(TW)) u_kyb (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(k_in_valid), .in_ready_o(k_in_ready),
    .a_i(k_a), .b_i(k_b), .tag_i(k_tag),
    .out_valid_o(k_out_valid), .out_ready_i(k_out_ready),
    .result_o(k_res), .tag_o(k_tag_o)
`ifdef RED_MUL_RANGE_CHECK_EN
    , .err_o(k_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  tag;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned exp;
  } vec_t;

  exp_t qa[$];
  exp_t qk[$];

  int          n_checks;
  int          n_errors;
  int          cyc;
  bit          lat_mode;
  bit          acc_a, acc_k;
  logic [31:0] a_exp, k_exp;
  logic        a_exp_err, k_exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_a();
    acc_a = 1'b0;
    if (rst_n) begin
      if (a_out_valid) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL a_unexpected: out_valid with result %0d, expected no output", a_res);
        end else begin
          check("a_result", 64'(a_res), 64'(qa[0].res));
          check("a_tag", 64'(a_tag_o), 64'(qa[0].tag));
`ifdef RED_MUL_RANGE_CHECK_EN
          check("a_err", 64'(a_err), 64'(qa[0].err));
`endif
          if (a_out_ready) begin
            if (qa[0].lat) check("a_latency", 64'(cyc - qa[0].acc), 64'd4);
            void'(qa.pop_front());
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        qa.push_back('{res: a_exp, tag: a_tag, err: a_exp_err, acc: cyc, lat: lat_mode});
        acc_a = 1'b1;
      end
    end
  endtask

  task automatic mon_k();
    acc_k = 1'b0;
    if (rst_n) begin
      if (k_out_valid) begin
        if (qk.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL k_unexpected: out_valid with result %0d, expected no output", k_res);
        end else begin
          check("k_result", 64'(k_res), 64'(qk[0].res));
          check("k_tag", 64'(k_tag_o), 64'(qk[0].tag));
`ifdef RED_MUL_RANGE_CHECK_EN
          check("k_err", 64'(k_err), 64'(qk[0].err));
`endif
          if (k_out_ready) begin
            if (qk[0].lat) check("k_latency", 64'(cyc - qk[0].acc), 64'd4);
            void'(qk.pop_front());
          end
        end
      end
      if (k_in_valid && k_in_ready) begin
        qk.push_back('{res: k_exp, tag: k_tag, err: k_exp_err, acc: cyc, lat: lat_mode});
        acc_k = 1'b1;
      end
    end
  endtask

  // Sample at the falling edge, then move to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    mon_a();
    mon_k();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (qa.size() != 0 || qk.size() != 0); c++) tick();
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_k", 64'(qk.size()), 64'd0);
  endtask

  vec_t dil_vec[9];
  vec_t kyb_vec[5];
  int   idx;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; lat_mode = 1'b0;
    acc_a = 1'b0; acc_k = 1'b0;
    a_exp = '0; k_exp = '0; a_exp_err = 1'b0; k_exp_err = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_a = '0; a_b = '0; a_tag = '0;
    k_in_valid = 1'b0; k_out_ready = 1'b1; k_a = '0; k_b = '0; k_tag = '0;

    dil_vec[0] = '{8380416, 8380416, 1};
    dil_vec[1] = '{2, 4190209, 1};
    dil_vec[2] = '{0, 8380416, 0};
    dil_vec[3] = '{1, 1234567, 1234567};
    dil_vec[4] = '{4190208, 2, 8380416};
    dil_vec[5] = '{8380416, 2, 8380415};
    dil_vec[6] = '{1000000, 9, 619583};
    dil_vec[7] = '{3, 3, 9};
    dil_vec[8] = '{5, 7, 35};
    kyb_vec[0] = '{3328, 3328, 1};
    kyb_vec[1] = '{1665, 2, 1};
    kyb_vec[2] = '{3328, 1, 3328};
    kyb_vec[3] = '{0, 5, 0};
    kyb_vec[4] = '{100, 100, 13};

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_result", 64'(a_res), 64'd0);
    check("rst_tag", 64'(a_tag_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_k_in_ready", 64'(k_in_ready), 64'd1);

    // Back-to-back table vectors, no backpressure: exact 4-cycle latency
    lat_mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_a = WA'(dil_vec[i].a); a_b = WA'(dil_vec[i].b);
      a_tag = TW'(8'h10 + i); a_exp = dil_vec[i].exp; a_in_valid = 1'b1;
      tick();
      check("a_accept", 64'(acc_a), 64'd1);
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      k_a = WK'(kyb_vec[i].a); k_b = WK'(kyb_vec[i].b);
      k_tag = TW'(8'h20 + i); k_exp = kyb_vec[i].exp; k_in_valid = 1'b1;
      tick();
      check("k_accept", 64'(acc_k), 64'd1);
    end
    k_in_valid = 1'b0;
    drain();

    // Capacity: stalled output admits exactly four, then drains in order
    lat_mode = 1'b0;
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (idx < 6);
      a_a = WA'(idx + 1); a_b = WA'(1000 + idx); a_tag = TW'(8'h40 + idx);
      a_exp = 32'((idx + 1) * (1000 + idx));
      tick();
      if (acc_a) idx++;
    end
    check("cap_accepted", 64'(idx), 64'd4);
    check("cap_in_ready", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      a_in_valid = 1'b1;
      a_a = WA'(idx + 1); a_b = WA'(1000 + idx); a_tag = TW'(8'h40 + idx);
      a_exp = 32'((idx + 1) * (1000 + idx));
      tick();
      if (acc_a) idx++;
    end
    a_in_valid = 1'b0;
    check("cap_total", 64'(idx), 64'd6);
    drain();

    // Reset with three operations in flight
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      a_in_valid = 1'b1;
      a_a = WA'(idx + 2); a_b = WA'(idx + 3); a_tag = TW'(8'h60 + idx);
      a_exp = 32'((idx + 2) * (idx + 3));
      tick();
      if (acc_a) idx++;
    end
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_out_valid", 64'(a_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_result", 64'(a_res), 64'd0);
    check("mid_rst_tag", 64'(a_tag_o), 64'd0);
    qa.delete();
    qk.delete();
    tick(); tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    for (int c = 0; c < 6; c++) tick();
    check("post_rst_idle", 64'(a_out_valid), 64'd0);
    lat_mode = 1'b1;
    a_a = WA'(5); a_b = WA'(7); a_tag = TW'(8'h77); a_exp = 32'd35; a_in_valid = 1'b1;
    tick();
    check("post_rst_accept", 64'(acc_a), 64'd1);
    a_in_valid = 1'b0;
    drain();

`ifdef RED_MUL_RANGE_CHECK_EN
    // Out-of-range operand is flagged and zeroed; the next operation is clean
    a_a = WA'(QA); a_b = WA'(1); a_tag = TW'(8'h88); a_exp = 32'd0; a_exp_err = 1'b1;
    a_in_valid = 1'b1;
    tick();
    a_a = WA'(3); a_b = WA'(3); a_tag = TW'(8'h89); a_exp = 32'd9; a_exp_err = 1'b0;
    tick();
    a_in_valid = 1'b0;
    drain();
`endif

    // Random Kyber operands with random valid and ready stalls
    lat_mode = 1'b0;
    idx = 0;
    for (int c = 0; c < 4000; c++) begin
      if (acc_k || !k_in_valid) begin
        k_in_valid = ($urandom_range(0, 9) < 7);
        k_a = WK'($urandom_range(0, QK - 1));
        k_b = WK'($urandom_range(0, QK - 1));
        k_tag = TW'($urandom_range(0, 255));
        k_exp = 32'((32'(k_a) * 32'(k_b)) % QK);
      end
      k_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc_k) idx++;
    end
    k_in_valid = 1'b0;
    k_out_ready = 1'b1;
    drain();
    check("rand_progress", 64'(idx > 1000), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
